// File: rtl/modulo_02_syndrome.sv
// SECDED syndrome detector for an 8-bit extended Hamming(7,4) word with a registered output stage.
// Optional macro MODULO02_CORR_EN adds the registered corrected-data output data_corr.
module modulo_02_syndrome (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] conmutador_8,
   output logic [3:0] sindrome_detec,
   output logic       out_valid,
   output logic       no_error,
   output logic       single_err,
   output logic       double_err,
   output logic [2:0] err_pos
`ifdef MODULO02_CORR_EN
   ,
   output logic [3:0] data_corr
`endif
);

   logic [3:0] w_s;
   logic       w_zero;
   logic       w_no_error;
   logic       w_single;
   logic       w_double;

   logic [3:0] r_syn;
   logic       r_vld;
   logic       r_no_error;
   logic       r_single;
   logic       r_double;
   logic [2:0] r_pos;

   assign w_s[0] = conmutador_8[0] ^ conmutador_8[2] ^ conmutador_8[4] ^ conmutador_8[6];
   assign w_s[1] = conmutador_8[1] ^ conmutador_8[2] ^ conmutador_8[5] ^ conmutador_8[6];
   assign w_s[2] = conmutador_8[3] ^ conmutador_8[4] ^ conmutador_8[5] ^ conmutador_8[6];
   // s3 is set when overall parity is even, i.e. no odd number of flips
   assign w_s[3] = ~(^conmutador_8);

   assign w_zero     = (w_s[2:0] == 3'd0);
   assign w_no_error = w_s[3] & w_zero;
   assign w_single   = ~w_s[3];
   assign w_double   = w_s[3] & ~w_zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_syn      <= 4'b0000;
         r_vld      <= 1'b0;
         r_no_error <= 1'b0;
         r_single   <= 1'b0;
         r_double   <= 1'b0;
         r_pos      <= 3'd0;
      end else begin
         r_vld <= in_valid;
         if (in_valid) begin
            r_syn      <= w_s;
            r_no_error <= w_no_error;
            r_single   <= w_single;
            r_double   <= w_double;
            r_pos      <= w_s[2:0];
         end
      end
   end

   assign sindrome_detec = r_syn;
   assign out_valid      = r_vld;
   assign no_error       = r_no_error;
   assign single_err     = r_single;
   assign double_err     = r_double;
   assign err_pos        = r_pos;

`ifdef MODULO02_CORR_EN
   logic [3:0] w_data;
   logic [3:0] w_flip;
   logic [3:0] r_data;

   assign w_data = {conmutador_8[6], conmutador_8[5], conmutador_8[4], conmutador_8[2]};

   // Only positions 3,5,6,7 carry data; parity-position errors leave data untouched
   always_comb begin
      w_flip = 4'b0000;
      if (w_single) begin
         case (w_s[2:0])
            3'd3:    w_flip = 4'b0001;
            3'd5:    w_flip = 4'b0010;
            3'd6:    w_flip = 4'b0100;
            3'd7:    w_flip = 4'b1000;
            default: w_flip = 4'b0000;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= 4'b0000;
      end else if (in_valid) begin
         r_data <= w_data ^ w_flip;
      end
   end

   assign data_corr = r_data;
`endif

endmodule

// File: tb/tb_modulo_02_syndrome.sv
// Scoreboard bench for modulo_02_syndrome: stimulus pushes expected results, a monitor pops and compares.
module tb_modulo_02_syndrome;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] conmutador_8;
   logic [3:0] sindrome_detec;
   logic       out_valid;
   logic       no_error;
   logic       single_err;
   logic       double_err;
   logic [2:0] err_pos;
`ifdef MODULO02_CORR_EN
   logic [3:0] data_corr;
`endif

   modulo_02_syndrome dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .conmutador_8   (conmutador_8),
      .sindrome_detec (sindrome_detec),
      .out_valid      (out_valid),
      .no_error       (no_error),
      .single_err     (single_err),
      .double_err     (double_err),
      .err_pos        (err_pos)
`ifdef MODULO02_CORR_EN
      ,
      .data_corr      (data_corr)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0] syn;
      logic       ne;
      logic       se;
      logic       de;
      logic [2:0] pos;
      logic [3:0] corr;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(input logic [7:0] b);
      exp_t e;
      logic [7:0] c;
      e.syn[0] = b[0] ^ b[2] ^ b[4] ^ b[6];
      e.syn[1] = b[1] ^ b[2] ^ b[5] ^ b[6];
      e.syn[2] = b[3] ^ b[4] ^ b[5] ^ b[6];
      e.syn[3] = ~(^b);
      e.ne  = e.syn[3] & (e.syn[2:0] == 3'd0);
      e.se  = ~e.syn[3];
      e.de  = e.syn[3] & (e.syn[2:0] != 3'd0);
      e.pos = e.syn[2:0];
      c = b;
      if (e.se && e.pos != 3'd0) c[e.pos - 3'd1] = ~c[e.pos - 3'd1];
      e.corr = {c[6], c[5], c[4], c[2]};
      e.cyc  = 0;
      return e;
   endfunction

   task automatic drive(input logic [7:0] b, input exp_t e);
      @(posedge clk); #1;
      in_valid     = 1'b1;
      conmutador_8 = b;
      e.cyc = cyc + 1;
      q.push_back(e);
   endtask

   // flags: 0 = no_error, 1 = single, 2 = double
   task automatic send_dir(input logic [7:0] b, input logic [3:0] syn, input int flag, input logic [2:0] pos);
      exp_t e;
      e = model(b);
      e.syn = syn;
      e.ne  = (flag == 0);
      e.se  = (flag == 1);
      e.de  = (flag == 2);
      e.pos = pos;
      drive(b, e);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_syn"}, 32'(sindrome_detec), 0);
      chk({name, "_vld"}, 32'(out_valid), 0);
      chk({name, "_flags"}, 32'({no_error, single_err, double_err}), 0);
      chk({name, "_pos"}, 32'(err_pos), 0);
`ifdef MODULO02_CORR_EN
      chk({name, "_corr"}, 32'(data_corr), 0);
`endif
   endtask

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         if (q.size() == 0) begin
            chk("stray_out_valid", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("latency", 32'(cyc), 32'(e.cyc));
            chk("syndrome", 32'(sindrome_detec), 32'(e.syn));
            chk("flags", 32'({no_error, single_err, double_err}), 32'({e.ne, e.se, e.de}));
            if (e.se) chk("err_pos", 32'(err_pos), 32'(e.pos));
`ifdef MODULO02_CORR_EN
            chk("data_corr", 32'(data_corr), 32'(e.corr));
`endif
         end
      end
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      conmutador_8 = 8'h00;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      send_dir(8'b11100001, 4'b1000, 0, 3'd0);
      idle();
      idle();
      send_dir(8'b11000001, 4'b0110, 1, 3'd6);
      send_dir(8'b11101001, 4'b0100, 1, 3'd4);
      send_dir(8'b10000001, 4'b1001, 2, 3'd0);
      send_dir(8'b00000000, 4'b1000, 0, 3'd0);
      send_dir(8'b11111111, 4'b1000, 0, 3'd0);
      idle();
      idle();

      // back-to-back then hold
      send_dir(8'b11100001, 4'b1000, 0, 3'd0);
      send_dir(8'b11000001, 4'b0110, 1, 3'd6);
      idle();
      @(negedge clk);
      @(negedge clk);
      chk("hold_vld", 32'(out_valid), 0);
      chk("hold_syn", 32'(sindrome_detec), 32'(4'b0110));
      chk("hold_pos", 32'(err_pos), 32'(3'd6));

      // reset wins over a valid sample
      @(posedge clk); #1;
      rst = 1'b1;
      in_valid = 1'b1;
      conmutador_8 = 8'b10000001;
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk_zero("midrst");

      for (int i = 0; i < 256; i++) drive(8'(i), model(8'(i)));
      idle();

`ifdef MODULO02_CORR_EN
      for (int d = 0; d < 16; d++) begin
         logic [7:0] cw;
         logic [3:0] dv;
         dv = 4'(d);
         cw[2] = dv[0]; cw[4] = dv[1]; cw[5] = dv[2]; cw[6] = dv[3];
         cw[0] = cw[2] ^ cw[4] ^ cw[6];
         cw[1] = cw[2] ^ cw[5] ^ cw[6];
         cw[3] = cw[4] ^ cw[5] ^ cw[6];
         cw[7] = ^cw[6:0];
         for (int k = 0; k < 8; k++) begin
            logic [7:0] f;
            exp_t e;
            f = cw;
            f[k] = ~f[k];
            e = model(f);
            e.corr = dv;
            drive(f, e);
         end
      end
      idle();
`endif

      for (int t = 0; t < 20 && q.size() != 0; t++) @(posedge clk);
      @(negedge clk);
      if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
